// File: rtl/cpu_run_controller.sv
// Run/halt/single-step sequencer: debounces the run switch and step button,
// gates the CPU clock-enable, stops on a PC breakpoint and counts enabled cycles.
module cpu_run_controller #(
  parameter int PC_WIDTH        = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                   clock,
  input  logic                   isReset,
  input  logic                   switch,
  input  logic                   stepButton,
  input  logic [PC_WIDTH-1:0]    pc,
  input  logic                   breakEnable,
  input  logic [PC_WIDTH-1:0]    breakAddress,
  output logic                   cpuEnable,
  output logic                   halted,
  output logic                   breakHit,
  output logic [1:0]             state,
  output logic [COUNT_WIDTH-1:0] cycleCount
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE = DW'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    BREAK = 2'd3
  } runState_t;

  runState_t curState;
  logic skip;

  // Index 0 is the run switch, index 1 is the step button.
  logic [1:0]          rawIn;
  logic [1:0]          sync1;
  logic [1:0]          sync2;
  logic [1:0]          level;
  logic [1:0][DW-1:0]  debCount;
  logic                stepPrev;

  logic switchLevel;
  logic stepReq;
  logic match;

  assign rawIn       = {stepButton, switch};
  assign switchLevel = level[0];
  assign stepReq     = level[1] & ~stepPrev;
  assign match       = breakEnable && (pc == breakAddress) && !skip;

  assign cpuEnable = !isReset && ((curState == RUN && !match) || curState == STEP);
  assign state     = curState;
  assign halted    = (curState == HALT) || (curState == BREAK);
  assign breakHit  = (curState == BREAK);

  // A filtered level only follows its synchronized input after DEBOUNCE_CYCLES
  // consecutive disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clock) begin
    if (isReset) begin
      sync1    <= '0;
      sync2    <= '0;
      level    <= '0;
      debCount <= '0;
      stepPrev <= 1'b0;
    end else begin
      sync1    <= rawIn;
      sync2    <= sync1;
      stepPrev <= level[1];
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != level[i]) begin
          if (debCount[i] == DEB_MAX) begin
            level[i]    <= sync2[i];
            debCount[i] <= '0;
          end else begin
            debCount[i] <= debCount[i] + DEB_ONE;
          end
        end else begin
          debCount[i] <= '0;
        end
      end
    end
  end

  // Skip is only true for the first RUN cycle after leaving HALT, so a resume
  // from the breakpoint PC executes that instruction instead of re-breaking.
  always_ff @(posedge clock) begin
    if (isReset) begin
      curState   <= HALT;
      skip       <= 1'b0;
      cycleCount <= '0;
    end else begin
      if (cpuEnable && cycleCount != '1)
        cycleCount <= cycleCount + COUNT_ONE;
      case (curState)
        HALT: begin
          if (stepReq) begin
            curState <= STEP;
          end else if (switchLevel) begin
            curState <= RUN;
            skip     <= 1'b1;
          end
        end
        RUN: begin
          skip <= 1'b0;
          if (!switchLevel)
            curState <= HALT;
          else if (match)
            curState <= BREAK;
        end
        STEP: curState <= HALT;
        BREAK: begin
          if (stepReq)
            curState <= STEP;
          else if (!switchLevel)
            curState <= HALT;
        end
        default: curState <= HALT;
      endcase
    end
  end

endmodule
